// File: rtl/evt_stream_mode_selector_if.sv
// Event-stream bus bundle for the per-slice source selector: N_SRC source
// streams and one engine-side stream per slice.
interface evt_stream_mode_selector_if #(
  parameter int unsigned SLICE_NUMBER = 8,
  parameter int unsigned N_SRC        = 2,
  parameter int unsigned EVT_WIDTH    = 32
);

  logic [SLICE_NUMBER*N_SRC-1:0]           src_valid;
  logic [SLICE_NUMBER*N_SRC*EVT_WIDTH-1:0] src_data;
  logic [SLICE_NUMBER*N_SRC-1:0]           src_ready;
  logic [SLICE_NUMBER-1:0]                 dst_valid;
  logic [SLICE_NUMBER*EVT_WIDTH-1:0]       dst_data;
  logic [SLICE_NUMBER-1:0]                 dst_ready;

  // Master drives the sources and the engine-side ready; slave is the selector.
  modport master (
    output src_valid, src_data, dst_ready,
    input  src_ready, dst_valid, dst_data
  );

  modport slave (
    input  src_valid, src_data, dst_ready,
    output src_ready, dst_valid, dst_data
  );

endinterface

// File: rtl/evt_stream_mode_selector.sv
// Per-slice N-way event-stream source selector with hitless source switching,
// a 2-entry output buffer and a saturating dropped-event counter per slice.
module evt_stream_mode_selector #(
  parameter  int unsigned SLICE_NUMBER = 8,
  parameter  int unsigned N_SRC        = 2,
  parameter  int unsigned EVT_WIDTH    = 32,
  parameter  int unsigned CNT_W        = 16,
  localparam int unsigned SEL_W        = $clog2(N_SRC)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [SLICE_NUMBER*SEL_W-1:0]   sel_i,
  input  logic [SLICE_NUMBER-1:0]         drop_unsel_i,
  input  logic                            clr_cnt_i,
  evt_stream_mode_selector_if.slave       evt_if,
  output logic [SLICE_NUMBER*SEL_W-1:0]   active_sel_o,
  output logic [SLICE_NUMBER-1:0]         busy_o,
  output logic [SLICE_NUMBER*CNT_W-1:0]   drop_cnt_o
);

  localparam int unsigned DROP_W = $clog2(N_SRC + 1);
  localparam int unsigned SUM_W  = CNT_W + DROP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  for (genvar s = 0; s < int'(SLICE_NUMBER); s++) begin : g_slice

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      active_q, active_d;
    logic [EVT_WIDTH-1:0]  mem_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [SEL_W-1:0]      sel_s;
    logic [N_SRC-1:0]      valid_s;
    logic                  dst_ready_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  act_ready_s;
    logic                  granted_s;

    logic [N_SRC-1:0]      ready_c;
    logic                  push_c;
    logic [EVT_WIDTH-1:0]  push_data_c;
    logic [DROP_W-1:0]     drops_c;
    logic [SUM_W-1:0]      sum_c;

    assign sel_s       = sel_i[s*SEL_W +: SEL_W];
    assign valid_s     = evt_if.src_valid[s*N_SRC +: N_SRC];
    assign dst_ready_s = evt_if.dst_ready[s];
    assign full_s      = (count_q == 2'd2);
    assign pop_s       = (count_q != 2'd0) && dst_ready_s;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign act_ready_s = !full_s || dst_ready_s;
    // An out-of-range active select grants nobody.
    assign granted_s   = (state_q == ST_RUN) && (32'(active_q) < N_SRC);

    // Output process: source readies, buffer push and per-cycle drop count.
    always_comb begin
      ready_c     = '0;
      push_c      = 1'b0;
      push_data_c = '0;
      drops_c     = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
        if (granted_s && (32'(active_q) == k)) begin
          ready_c[k]  = act_ready_s;
          push_c      = valid_s[k] && act_ready_s;
          push_data_c = evt_if.src_data[(s*N_SRC + k)*EVT_WIDTH +: EVT_WIDTH];
        end else begin
          ready_c[k] = drop_unsel_i[s];
          if (drop_unsel_i[s] && valid_s[k]) begin
            drops_c = drops_c + DROP_W'(1);
          end
        end
      end
    end

    // Next-state process: FIFO pointers, RUN/DRAIN sequencing, drop counter.
    always_comb begin
      state_d  = state_q;
      active_d = active_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + 2'(push_c) - 2'(pop_s);
      cnt_d    = cnt_q;
      sum_c    = SUM_W'(cnt_q) + SUM_W'(drops_c);

      if (push_c) wr_ptr_d = ~wr_ptr_q;
      if (pop_s)  rd_ptr_d = ~rd_ptr_q;

      case (state_q)
        ST_RUN: begin
          if (sel_s != active_q) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          // Switch once the buffer is empty, even if sel_i went back.
          if (count_d == 2'd0) begin
            active_d = sel_s;
            state_d  = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase

      if (clr_cnt_i) begin
        cnt_d = '0;
      end else if (sum_c > SUM_W'(CNT_MAX)) begin
        cnt_d = CNT_MAX;
      end else begin
        cnt_d = sum_c[CNT_W-1:0];
      end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q  <= ST_RUN;
        active_q <= '0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        count_q  <= 2'd0;
        cnt_q    <= '0;
        mem_q[0] <= '0;
        mem_q[1] <= '0;
      end else begin
        state_q  <= state_d;
        active_q <= active_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        cnt_q    <= cnt_d;
        if (push_c) mem_q[wr_ptr_q] <= push_data_c;
      end
    end

    assign evt_if.src_ready[s*N_SRC +: N_SRC]         = ready_c;
    assign evt_if.dst_valid[s]                        = (count_q != 2'd0);
    assign evt_if.dst_data[s*EVT_WIDTH +: EVT_WIDTH]  = mem_q[rd_ptr_q];
    assign active_sel_o[s*SEL_W +: SEL_W]             = active_q;
    assign busy_o[s]                                  = (state_q == ST_DRAIN);
    assign drop_cnt_o[s*CNT_W +: CNT_W]               = cnt_q;

  end : g_slice

endmodule

// File: tb/tb_evt_stream_mode_selector.sv
// Directed bench for evt_stream_mode_selector: a default-sized instance for
// streaming/switch/drop/reset cases and a 3-source, 4-bit-counter instance for saturation.
module tb_evt_stream_mode_selector;

  logic clk;
  logic rst_n;

  // Default configuration: 8 slices, 2 sources, 32-bit events, 16-bit counters.
  logic [7:0]   sel;
  logic [7:0]   drop_unsel;
  logic         clr;
  logic [7:0]   active;
  logic [7:0]   busy;
  logic [127:0] cnt;

  // Saturation configuration: 1 slice, 3 sources (select 3 is out of range), 4-bit counter.
  logic [1:0]   sel5;
  logic [0:0]   drop_unsel5;
  logic [1:0]   active5;
  logic [0:0]   busy5;
  logic [3:0]   cnt5;

  int n_checks = 0;
  int n_fail   = 0;

  evt_stream_mode_selector_if #(.SLICE_NUMBER(8), .N_SRC(2), .EVT_WIDTH(32)) bus ();
  evt_stream_mode_selector_if #(.SLICE_NUMBER(1), .N_SRC(3), .EVT_WIDTH(8))  bus5 ();

  evt_stream_mode_selector #(
    .SLICE_NUMBER(8), .N_SRC(2), .EVT_WIDTH(32), .CNT_W(16)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sel_i        (sel),
    .drop_unsel_i (drop_unsel),
    .clr_cnt_i    (clr),
    .evt_if       (bus.slave),
    .active_sel_o (active),
    .busy_o       (busy),
    .drop_cnt_o   (cnt)
  );

  evt_stream_mode_selector #(
    .SLICE_NUMBER(1), .N_SRC(3), .EVT_WIDTH(8), .CNT_W(4)
  ) u_dut_sat (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sel_i        (sel5),
    .drop_unsel_i (drop_unsel5),
    .clr_cnt_i    (clr),
    .evt_if       (bus5.slave),
    .active_sel_o (active5),
    .busy_o       (busy5),
    .drop_cnt_o   (cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n           = 1'b1;
    sel             = '0;
    drop_unsel      = '0;
    clr             = 1'b0;
    sel5            = '0;
    drop_unsel5     = '0;
    bus.src_valid   = '0;
    bus.src_data    = '0;
    bus.dst_ready   = '0;
    bus5.src_valid  = '0;
    bus5.src_data   = '0;
    bus5.dst_ready  = '0;
    #2 rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_dst_valid", 64'(bus.dst_valid), 64'h0);
    check("rst_busy",      64'(busy),          64'h0);
    check("rst_active",    64'(active),        64'h0);
    check("rst_drop_cnt",  64'(cnt[63:0]),     64'h0);
    check("rst_sat_valid", 64'(bus5.dst_valid), 64'h0);
    rst_n = 1'b1;

    // 1: ten events, one per cycle, one cycle latency
    bus.dst_ready = '1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.src_valid[0]     = (i < 10);
      bus.src_data[31:0]   = 32'h100 + 32'(i);
      #1;
      if (i < 10) check("t1_ready", 64'(bus.src_ready[0]), 64'h1);
      check("t1_valid", 64'(bus.dst_valid[0]), 64'((i >= 1) && (i <= 10)));
      if ((i >= 1) && (i <= 10)) check("t1_data", 64'(bus.dst_data[31:0]), 64'h100 + 64'(i - 1));
    end

    // 2: backpressure fills both entries, then drains in order
    @(negedge clk);
    bus.dst_ready[0] = 1'b0;
    bus.src_valid[0] = 1'b1;
    bus.src_data[31:0] = 32'h200;
    #1 check("t2_ready0", 64'(bus.src_ready[0]), 64'h1);
    @(negedge clk);
    bus.src_data[31:0] = 32'h201;
    #1 check("t2_ready1", 64'(bus.src_ready[0]), 64'h1);
    @(negedge clk);
    bus.src_data[31:0] = 32'h202;
    #1;
    check("t2_full_ready", 64'(bus.src_ready[0]), 64'h0);
    check("t2_head",       64'(bus.dst_data[31:0]), 64'h200);
    @(negedge clk);
    bus.src_valid[0] = 1'b0;
    bus.dst_ready[0] = 1'b1;
    #1 check("t2_out0", 64'(bus.dst_data[31:0]), 64'h200);
    @(negedge clk);
    bus.src_valid[0] = 1'b1;
    #1;
    check("t2_ready2", 64'(bus.src_ready[0]), 64'h1);
    check("t2_out1",   64'(bus.dst_data[31:0]), 64'h201);
    @(negedge clk);
    bus.src_valid[0] = 1'b0;
    #1 check("t2_out2", 64'(bus.dst_data[31:0]), 64'h202);
    @(negedge clk);
    #1 check("t2_empty", 64'(bus.dst_valid[0]), 64'h0);

    // 3: switch 0->1 with two events buffered
    @(negedge clk);
    bus.dst_ready[0] = 1'b0;
    bus.src_valid[0] = 1'b1;
    bus.src_data[31:0] = 32'h300;
    @(negedge clk);
    bus.src_data[31:0] = 32'h301;
    @(negedge clk);
    bus.src_valid[0] = 1'b0;
    sel[0] = 1'b1;
    bus.src_valid[1] = 1'b1;
    bus.src_data[63:32] = 32'h3A0;
    #1;
    check("t3_src1_blocked_run", 64'(bus.src_ready[1]), 64'h0);
    check("t3_busy_run",         64'(busy[0]),          64'h0);
    @(negedge clk);
    bus.dst_ready[0] = 1'b1;
    #1;
    check("t3_busy_drain",   64'(busy[0]),          64'h1);
    check("t3_src1_blocked", 64'(bus.src_ready[1]), 64'h0);
    check("t3_src0_blocked", 64'(bus.src_ready[0]), 64'h0);
    check("t3_drain0",       64'(bus.dst_data[31:0]), 64'h300);
    @(negedge clk);
    #1;
    check("t3_busy_drain2",  64'(busy[0]),          64'h1);
    check("t3_drain1",       64'(bus.dst_data[31:0]), 64'h301);
    check("t3_src1_blocked2", 64'(bus.src_ready[1]), 64'h0);
    @(negedge clk);
    #1;
    check("t3_busy_done",  64'(busy[0]),          64'h0);
    check("t3_active",     64'(active[0]),        64'h1);
    check("t3_empty",      64'(bus.dst_valid[0]), 64'h0);
    check("t3_src1_ready", 64'(bus.src_ready[1]), 64'h1);
    @(negedge clk);
    bus.src_valid[1] = 1'b0;
    #1;
    check("t3_src1_valid", 64'(bus.dst_valid[0]),  64'h1);
    check("t3_src1_data",  64'(bus.dst_data[31:0]), 64'h3A0);

    // 4: drop counting on the unselected source while src0 streams
    @(negedge clk);
    sel[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("t4_active", 64'(active[0]), 64'h0);
    check("t4_busy",   64'(busy[0]),   64'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drop_unsel[0]      = 1'b1;
      bus.src_valid[1:0] = 2'b11;
      bus.src_data[31:0] = 32'h400 + 32'(i);
      #1;
      check("t4_src1_ready", 64'(bus.src_ready[1]), 64'h1);
      check("t4_src0_ready", 64'(bus.src_ready[0]), 64'h1);
      if (i > 0) check("t4_src0_data", 64'(bus.dst_data[31:0]), 64'h400 + 64'(i - 1));
    end
    @(negedge clk);
    bus.src_valid[1:0] = 2'b00;
    #1;
    check("t4_cnt5",      64'(cnt[15:0]),        64'd5);
    check("t4_last",      64'(bus.dst_data[31:0]), 64'h404);
    check("t4_slice1_cnt", 64'(cnt[31:16]),      64'd0);
    @(negedge clk);
    clr = 1'b1;
    bus.src_valid[1] = 1'b1;
    #1 check("t4_cnt_before_clr", 64'(cnt[15:0]), 64'd5);
    @(negedge clk);
    clr = 1'b0;
    bus.src_valid[1] = 1'b0;
    #1 check("t4_cnt_cleared", 64'(cnt[15:0]), 64'd0);
    @(negedge clk);
    drop_unsel[0] = 1'b0;
    bus.src_valid[1] = 1'b1;
    #1 check("t4_stall_ready", 64'(bus.src_ready[1]), 64'h0);
    @(negedge clk);
    bus.src_valid[1] = 1'b0;
    #1 check("t4_cnt_stall", 64'(cnt[15:0]), 64'd0);

    // 5: out-of-range select, all three sources dropped, counter saturates
    @(negedge clk);
    sel5 = 2'd3;
    repeat (3) @(negedge clk);
    #1;
    check("t5_active", 64'(active5),         64'd3);
    check("t5_busy",   64'(busy5),           64'd0);
    check("t5_stall",  64'(bus5.src_ready),  64'h0);
    @(negedge clk);
    drop_unsel5    = 1'b1;
    bus5.src_valid = 3'b111;
    #1 check("t5_ready_all", 64'(bus5.src_ready), 64'h7);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      #1;
      check("t5_cnt", 64'(cnt5), (3 * n > 15) ? 64'd15 : 64'(3 * n));
      check("t5_no_dst", 64'(bus5.dst_valid), 64'h0);
    end
    bus5.src_valid = '0;

    // 6: reset while draining with one event buffered
    @(negedge clk);
    bus.dst_ready[0] = 1'b0;
    bus.src_valid[0] = 1'b1;
    bus.src_data[31:0] = 32'h600;
    @(negedge clk);
    bus.src_valid[0] = 1'b0;
    sel[0] = 1'b1;
    #1 check("t6_buffered", 64'(bus.dst_valid[0]), 64'h1);
    @(negedge clk);
    #1 check("t6_busy", 64'(busy[0]), 64'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid",  64'(bus.dst_valid[0]), 64'h0);
    check("t6_rst_active", 64'(active[0]),        64'h0);
    check("t6_rst_busy",   64'(busy[0]),          64'h0);
    @(negedge clk);
    sel[0] = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
